// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator display path: FSM states,
// special segment patterns and the BCD-digit to 7-segment encoder.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SHOW
    } disp_state_t;

    // Segment order {g,f,e,d,c,b,a}, active-low (common-anode display).
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Largest value representable on n_dig decimal digits (9999 for 4).
    function automatic int max_shown(input int n_dig);
        int v;
        v = 1;
        for (int i = 0; i < n_dig; i++) v = v * 10;
        return v - 1;
    endfunction

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/display_resultado_if.sv
// Load-side handshake between the ALU result register and the display block.
interface display_resultado_if #(
    parameter int W_IN = 14
);
    logic [W_IN-1:0] result;
    logic            load_valid;
    logic            busy;
    logic            done;
    logic            ovf;

    modport master (
        output result, load_valid,
        input  busy, done, ovf
    );

    modport slave (
        input  result, load_valid,
        output busy, done, ovf
    );
endinterface

// File: rtl/display_resultado_bin2bcd.sv
// Sequential double-dabble: one add-3/shift step per clock, W_IN steps per
// conversion; the digits and overflow flag are committed on the last step.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int W_IN  = 14,
    parameter int N_DIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [W_IN-1:0]     bin,
    output logic                busy,
    output logic                done,
    output logic [4*N_DIG-1:0]  bcd,
    output logic                ovf
);

    localparam int BCD_W = 4 * N_DIG;
    localparam int SR_W  = BCD_W + W_IN;
    localparam int CW    = (W_IN > 1) ? $clog2(W_IN) : 1;
    localparam logic [CW-1:0] LAST = CW'(W_IN - 1);
    localparam int MAXV  = max_shown(N_DIG);

    logic [SR_W-1:0] sr;
    logic [SR_W-1:0] sr_adj;
    logic [SR_W-1:0] sr_next;
    logic [CW-1:0]   cnt;
    logic            big;

    // NOTE: every variable written here gets its default first, so no latch
    // is inferred when the per-nibble condition is false.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < N_DIG; i++) begin
            if (sr_adj[W_IN + 4*i +: 4] >= 4'd5)
                sr_adj[W_IN + 4*i +: 4] = sr_adj[W_IN + 4*i +: 4] + 4'd3;
        end
        sr_next = {sr_adj[SR_W-2:0], 1'b0};
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            bcd  <= '0;
            ovf  <= 1'b0;
            big  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                sr  <= sr_next;
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    bcd  <= sr_next[SR_W-1 -: BCD_W];
                    ovf  <= big;
                end
            end else if (start) begin
                sr   <= {{BCD_W{1'b0}}, bin};
                cnt  <= '0;
                busy <= 1'b1;
                // The shift register only holds N_DIG digits, so a fifth digit
                // is detected from the binary input instead.
                big  <= (32'(bin) > 32'(MAXV));
            end
        end
    end

endmodule

// File: rtl/display_resultado.sv
// Result display: converts the loaded binary value to BCD and scans it onto a
// multiplexed common-anode 7-segment display with leading-zero blanking.
module display_resultado
    import calc_pkg::*;
#(
    parameter int W_IN        = 14,
    parameter int N_DIG       = 4,
    parameter int REFRESH_DIV = 27000
) (
    input  logic               clk,
    input  logic               rst,
    display_resultado_if.slave bus,
    output logic [6:0]         seg,
    output logic [N_DIG-1:0]   an
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N_DIG - 1);

    disp_state_t state, state_nxt;

    logic               conv_start;
    logic               conv_busy;
    logic               conv_done;
    logic               conv_ovf;
    logic [4*N_DIG-1:0] digits;
    logic               shown;

    logic [RW-1:0]      refresh;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      msd;
    logic [3:0]         nib;
    logic [6:0]         seg_d;
    logic [N_DIG-1:0]   an_d;

    // A strobe during a conversion is dropped, never queued.
    assign conv_start = bus.load_valid && (state != CONVERT);

    bin2bcd_seq #(
        .W_IN  (W_IN),
        .N_DIG (N_DIG)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (bus.result),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (digits),
        .ovf   (conv_ovf)
    );

    assign bus.busy = conv_busy;
    assign bus.done = conv_done;
    assign bus.ovf  = conv_ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.load_valid) state_nxt = CONVERT;
            CONVERT: if (conv_done)      state_nxt = SHOW;
            SHOW:    if (bus.load_valid) state_nxt = CONVERT;
            default:                     state_nxt = IDLE;
        endcase
    end

    // Keeps the display dark during the very first conversion after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           shown <= 1'b0;
        else if (conv_done) shown <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh <= '0;
            idx     <= '0;
        end else if (refresh == R_LAST) begin
            refresh <= '0;
            idx     <= (idx == I_LAST) ? '0 : idx + 1'b1;
        end else begin
            refresh <= refresh + 1'b1;
        end
    end

    always_comb begin
        msd = '0;
        for (int i = 1; i < N_DIG; i++) begin
            if (digits[4*i +: 4] != 4'd0) msd = IW'(i);
        end
        nib   = digits[4*int'(idx) +: 4];
        an_d  = '1;
        seg_d = SEG_BLANK;
        if ((state != IDLE) && shown) begin
            an_d[idx] = 1'b0;
            if (conv_ovf)       seg_d = SEG_DASH;
            else if (idx > msd) seg_d = SEG_BLANK;
            else                seg_d = bcd_to_seg(nib);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule
